// File: rtl/sha2_pkg.sv
// Shared constants for the SHA-2 message schedule: round counts, sigma
// rotate/shift amounts per word width, and the FSM encoding.
package sha2_pkg;

    localparam int CTR_W         = 7;
    localparam int SHA256_ROUNDS = 64;
    localparam int SHA512_ROUNDS = 80;

    // small sigma constants, SHA-256 (32-bit words)
    localparam int S256_S0_R1 = 7;
    localparam int S256_S0_R2 = 18;
    localparam int S256_S0_SH = 3;
    localparam int S256_S1_R1 = 17;
    localparam int S256_S1_R2 = 19;
    localparam int S256_S1_SH = 10;

    // small sigma constants, SHA-512 (64-bit words)
    localparam int S512_S0_R1 = 1;
    localparam int S512_S0_R2 = 8;
    localparam int S512_S0_SH = 7;
    localparam int S512_S1_R1 = 19;
    localparam int S512_S1_R2 = 61;
    localparam int S512_S1_SH = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sha2_w_sched_if.sv
// Valid/ready stream carrying schedule words from sha2_w_sched to the round core.
interface sha2_w_sched_if
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
);
    logic              w_valid;
    logic              w_ready;
    logic [WORD_W-1:0] w;
    logic [CTR_W-1:0]  w_idx;
    logic              w_last;

    modport master (output w_valid, output w, output w_idx, output w_last, input w_ready);
    modport slave  (input w_valid, input w, input w_idx, input w_last, output w_ready);
endinterface

// File: rtl/sha2_w_sigma.sv
// Small sigma functions s0/s1 of the SHA-2 message schedule; purely combinational.
module sha2_w_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] x1,
    input  logic [WORD_W-1:0] x14,
    output logic [WORD_W-1:0] s0,
    output logic [WORD_W-1:0] s1
);
    localparam bit W64 = (WORD_W == 64);
    localparam int S0_R1 = W64 ? S512_S0_R1 : S256_S0_R1;
    localparam int S0_R2 = W64 ? S512_S0_R2 : S256_S0_R2;
    localparam int S0_SH = W64 ? S512_S0_SH : S256_S0_SH;
    localparam int S1_R1 = W64 ? S512_S1_R1 : S256_S1_R1;
    localparam int S1_R2 = W64 ? S512_S1_R2 : S256_S1_R2;
    localparam int S1_SH = W64 ? S512_S1_SH : S256_S1_SH;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    assign s0 = rotr(x1, S0_R1) ^ rotr(x1, S0_R2) ^ (x1 >> S0_SH);
    assign s1 = rotr(x14, S1_R1) ^ rotr(x14, S1_R2) ^ (x14 >> S1_SH);
endmodule

// File: rtl/sha2_w_sched.sv
// SHA-2 message schedule: expands a 16-word block into ROUNDS W words on a
// valid/ready stream, with abort and restart-on-load.
module sha2_w_sched
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [16*WORD_W-1:0] block,
    input  logic                 load,
    input  logic                 abort,
    output logic                 busy,
    sha2_w_sched_if.master       w_if
);
    if (!((WORD_W == 32 && ROUNDS == SHA256_ROUNDS) ||
          (WORD_W == 64 && ROUNDS == SHA512_ROUNDS))) begin : g_bad_cfg
        $error("sha2_w_sched: illegal WORD_W/ROUNDS pairing");
    end

    localparam logic [CTR_W-1:0] LAST = CTR_W'(ROUNDS - 1);

    state_e                      state_q, state_d;
    logic [CTR_W-1:0]            ctr;
    logic [15:0][WORD_W-1:0]     win;
    logic [15:0][WORD_W-1:0]     blk;
    logic [WORD_W-1:0]           s0, s1, w_new, w_sel;
    logic                        xfer, expand;

    assign blk    = block;
    assign busy   = (state_q == ST_RUN);
    assign xfer   = busy && w_if.w_ready;
    assign expand = |ctr[CTR_W-1:4];

    sha2_w_sigma #(.WORD_W(WORD_W)) u_sigma (
        .x1  (win[1]),
        .x14 (win[14]),
        .s0  (s0),
        .s1  (s1)
    );

    assign w_new = s1 + win[9] + s0 + win[0];
    assign w_sel = expand ? w_new : win[ctr[3:0]];

    assign w_if.w_valid = busy;
    assign w_if.w       = busy ? w_sel : '0;
    assign w_if.w_idx   = ctr;
    assign w_if.w_last  = busy && (ctr == LAST);

    always_comb begin
        state_d = state_q;
        if (abort)
            state_d = ST_IDLE;
        else if (load)
            state_d = ST_RUN;
        else if (xfer && ctr == LAST)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Window holds W[t..t+15]; once expanding, each transfer slides it by one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctr <= '0;
            win <= '0;
        end else if (abort) begin
            ctr <= '0;
        end else if (load) begin
            ctr <= '0;
            for (int i = 0; i < 16; i++) win[i] <= blk[15-i];
        end else if (xfer) begin
            ctr <= (ctr == LAST) ? '0 : ctr + 1'b1;
            if (expand) begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= w_new;
            end
        end
    end
endmodule
